data_port_arbiter: RTL
======================

// Module: data_port_arbiter
// PURPOSE
// - Shares the data memory's second read port and its write port between the CPU's load/store stage and a debug/loader requester.
// - CPU has priority; a starvation counter guarantees the debug requester a slot.
// - A hold mode stalls the CPU and gives debug exclusive ownership, for program load and memory inspection.
// - Sits between the CPU load/store stage, the debug port and mem; read data is returned READ_LATENCY cycles after grant, tagged to its owner.
// PARAMETERS
// - READ_LATENCY  2   cycles from address on mem_raddr to valid mem_rdata (>=1)
// - STARVE_LIMIT  4   consecutive denied debug cycles before a forced grant (>=1)
// PORTS
// - clk          in   1     single clock; all state on posedge
// - reset        in   1     synchronous, active-high
// - cpu_req      in   1     CPU access valid this cycle
// - cpu_we       in   1     1=store, 0=load
// - cpu_addr     in   15    word address [15:1]
// - cpu_wdata    in   16    store data
// - cpu_stall    out  1     CPU request not accepted; CPU holds pipeline and request
// - cpu_rvalid   out  1     cpu_rdata valid
// - cpu_rdata    out  16    load data
// - dbg_req      in   1     debug access valid
// - dbg_we       in   1     1=write, 0=read
// - dbg_addr     in   15    word address [15:1]
// - dbg_wdata    in   16    write data
// - dbg_hold     in   1     request exclusive ownership (CPU halted)
// - dbg_gnt      out  1     debug access accepted this cycle
// - dbg_halted   out  1     CPU fully halted; debug owns the port
// - dbg_rvalid   out  1     dbg_rdata valid
// - dbg_rdata    out  16    read data
// - mem_raddr    out  15    to mem read port 1
// - mem_rdata    in   16    from mem read port 1
// - mem_wen      out  1     to mem write port
// - mem_waddr    out  15    to mem write port
// - mem_wdata    out  16    to mem write port
// BEHAVIOUR
// - Reset values: state RUN, starve count 0, tag pipe empty; all outputs 0.
//   Reads in flight at reset are dropped: no rvalid is produced for them.
// - Grant is combinational in the same cycle.
//   - Granted write: mem_wen=1 with the owner's addr/data.
//   - Granted read: mem_raddr=addr.
//   - No grant: mem_wen=0, mem_raddr=0.
// - Reads push an owner tag {NONE,CPU,DBG} into a READ_LATENCY-deep pipe.
//   - On exit, the owner's rvalid=1 for one cycle; both rdata outputs = mem_rdata.
// - State RUN:
//   - cpu_req=1 and count<STARVE_LIMIT: CPU granted, cpu_stall=0.
//   - Otherwise dbg_req=1: dbg granted; if cpu_req=1, cpu_stall=1.
//   - count: +1 when dbg_req & !dbg_gnt, 0 when dbg_gnt or !dbg_req; saturates at STARVE_LIMIT.
//   - dbg_hold=1: go to DRAIN next cycle. The current-cycle grant still follows the RUN rules.
// - State DRAIN:
//   - cpu_stall=1 for any cpu_req; debug granted on dbg_req.
//   - Go to HALTED once the tag pipe holds no CPU tag.
//   - dbg_hold=0: return to RUN.
// - State HALTED:
//   - dbg_halted=1, cpu_stall=1; dbg granted every dbg_req cycle.
//   - dbg_hold=0: go to RUN next cycle. dbg reads in flight still complete.
// - dbg_hold and the starvation threshold in the same cycle: hold wins. Count is cleared on entering DRAIN.
// - Write then read to the same address in consecutive cycles: ordering is the memory's; no bypass here.
// - Count width is $clog2(STARVE_LIMIT+1); no wrap.
// STRUCTURE
// - Shared include arb_defs.vh: owner tag localparams (OWN_NONE=0, OWN_CPU=1, OWN_DBG=2) and FSM state encodings (RUN, DRAIN, HALTED).
// - Sub-module rd_tag_pipe:
//   - Parameterised shift register of 2-bit tags.
//   - Outputs the tag at its head and a has_cpu_tag flag.
//   - Synchronous reset to OWN_NONE.
// TESTING
// - Reset mid-read: CPU read at 0x0040 granted, reset next cycle -> no cpu_rvalid ever; all outputs 0.
// - CPU-only load at 0x0010, mem holds 0x1234 -> cpu_rvalid=1 and cpu_rdata=0x1234 exactly 2 cycles after grant; cpu_stall=0 throughout.
// - cpu_req continuous, dbg_req read at 0x0100 -> dbg_gnt on the 5th cycle; cpu_stall=1 that cycle only; count returns to 0.
// - CPU idle, dbg write 0xBEEF to 0x0200 -> mem_wen=1, waddr=0x0100 ([15:1]), wdata=0xBEEF, same cycle.
// - CPU read in flight, dbg_hold=1 -> DRAIN 2 cycles, cpu_rvalid delivered, then dbg_halted=1.
//   Hold released -> RUN, cpu_stall=0 next cycle.
// - dbg_hold rises in the same cycle the count hits 4 -> DRAIN entered, count=0, no double grant.

Source files
------------

// File: rtl/data_port_arbiter_pkg.sv
// Shared types and constants for the data-port arbiter: owner tags, FSM states, request payload.
package data_port_arbiter_pkg;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned TAG_W  = 2;

   typedef logic [TAG_W-1:0] tag_t;

   localparam tag_t OWN_NONE = 2'd0;
   localparam tag_t OWN_CPU  = 2'd1;
   localparam tag_t OWN_DBG  = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // Owner tag pushed into the read pipe: only granted reads are tracked.
   function automatic tag_t read_tag(input logic gnt, input logic we, input tag_t owner);
      return (gnt && !we) ? owner : OWN_NONE;
   endfunction

endpackage

// File: rtl/data_port_arbiter_rd_tag_pipe.sv
// Shift register of read-owner tags; the head tag marks whose read data is on mem_rdata this cycle.
module data_port_arbiter_rd_tag_pipe
   import data_port_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [TAG_W-1:0] tag_in,
   output logic [TAG_W-1:0] tag_head,
   output logic             has_cpu_tag
);

   tag_t tag_q [DEPTH];
   tag_t tag_d [DEPTH];

   always_comb begin
      tag_d[0] = tag_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_q[i] <= OWN_NONE;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign tag_head = tag_q[DEPTH-1];

   // The head tag retires this cycle, so only the stages behind it count as still pending.
   always_comb begin
      has_cpu_tag = 1'b0;
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
         if (tag_q[i] == OWN_CPU) begin
            has_cpu_tag = 1'b1;
         end
      end
   end

endmodule

// File: rtl/data_port_arbiter.sv
// Shares mem read port 1 and the write port between the CPU load/store stage and the debug port.
// CPU has priority, a starvation counter forces debug slots, and hold mode halts the CPU.
module data_port_arbiter
   import data_port_arbiter_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic              dbg_hold,
   output logic              dbg_gnt,
   output logic              dbg_halted,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata
);

   localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic     cpu_gnt;
   logic     dbg_gnt_i;
   logic     stall_i;
   logic     has_cpu_tag;
   tag_t     tag_in;
   tag_t     tag_head;
   mem_req_t sel;

   // Grant decision, starvation count and ownership FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cpu_gnt   = 1'b0;
      dbg_gnt_i = 1'b0;
      stall_i   = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (cpu_req && (cnt_q < CNT_MAX)) begin
               cpu_gnt = 1'b1;
            end else if (dbg_req) begin
               dbg_gnt_i = 1'b1;
            end
            stall_i = cpu_req && !cpu_gnt;
            if (dbg_req && !dbg_gnt_i) begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
               cnt_d = '0;
            end
            if (dbg_hold) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end
         end
         ST_DRAIN: begin
            stall_i   = cpu_req;
            dbg_gnt_i = dbg_req;
            cnt_d     = '0;
            if (!dbg_hold) begin
               state_d = ST_RUN;
            end else if (!has_cpu_tag) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            stall_i   = 1'b1;
            dbg_gnt_i = dbg_req;
            cnt_d     = '0;
            if (!dbg_hold) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
      // Nothing is granted or stalled while reset is held.
      if (reset) begin
         cpu_gnt   = 1'b0;
         dbg_gnt_i = 1'b0;
         stall_i   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      if (cpu_gnt) begin
         sel.we    = cpu_we;
         sel.addr  = cpu_addr;
         sel.wdata = cpu_wdata;
      end else begin
         sel.we    = dbg_we;
         sel.addr  = dbg_addr;
         sel.wdata = dbg_wdata;
      end
   end

   // Memory port drive for the granted owner; idle ports stay at zero.
   always_comb begin
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_raddr = '0;
      if (cpu_gnt || dbg_gnt_i) begin
         if (sel.we) begin
            mem_wen   = 1'b1;
            mem_waddr = sel.addr;
            mem_wdata = sel.wdata;
         end else begin
            mem_raddr = sel.addr;
         end
      end
   end

   assign tag_in = cpu_gnt ? read_tag(cpu_gnt, cpu_we, OWN_CPU)
                           : read_tag(dbg_gnt_i, dbg_we, OWN_DBG);

   data_port_arbiter_rd_tag_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_rd_tag_pipe (
      .clk         (clk),
      .reset       (reset),
      .tag_in      (tag_in),
      .tag_head    (tag_head),
      .has_cpu_tag (has_cpu_tag)
   );

   assign cpu_stall  = stall_i;
   assign dbg_gnt    = dbg_gnt_i;
   assign dbg_halted = !reset && (state_q == ST_HALTED);
   assign cpu_rvalid = !reset && (tag_head == OWN_CPU);
   assign dbg_rvalid = !reset && (tag_head == OWN_DBG);
   assign cpu_rdata  = reset ? '0 : mem_rdata;
   assign dbg_rdata  = reset ? '0 : mem_rdata;

endmodule
